// File: rtl/video_raster_gen.sv
// Raster timing generator: pixel/line counters, sync and blank windows, tile fetch strobes,
// programmable line interrupts plus a frame interrupt, and a per-frame flash counter.
module video_raster_gen #(
  parameter int H_TOTAL  = 384,
  parameter int V_TOTAL  = 312,
  parameter int H_ACT    = 128,
  parameter int V_ACT    = 192,
  parameter int HB_START = 32,
  parameter int HB_END   = 112,
  parameter int HS_START = 48,
  parameter int HS_END   = 80,
  parameter int VS_START = 240,
  parameter int VS_END   = 244,
  parameter int VB_START = 236,
  parameter int VB_END   = 260,
  parameter int INT_HPOS = 3,
  parameter int NUM_LINT = 2,
  parameter int FLASH_W  = 5
) (
  input  logic                clk_sys,
  input  logic                reset_n,
  input  logic                ce_pix,
  input  logic                lint_we,
  input  logic [2:0]          lint_sel,
  input  logic [8:0]          lint_din,
  input  logic [NUM_LINT:0]   int_ack,
  output logic [8:0]          hc,
  output logic [8:0]          vc,
  output logic                hsync,
  output logic                hblank,
  output logic                vsync,
  output logic                vblank,
  output logic                fetch,
  output logic [4:0]          fetch_col,
  output logic [7:0]          fetch_row,
  output logic [FLASH_W-1:0]  flashcnt,
  output logic [NUM_LINT:0]   int_pend,
  output logic                irq
);

  localparam logic [8:0] H_LAST     = 9'(H_TOTAL - 1);
  localparam logic [8:0] V_LAST     = 9'(V_TOTAL - 1);
  localparam logic [8:0] H_ACT9     = 9'(H_ACT);
  localparam logic [8:0] V_ACT9     = 9'(V_ACT);
  localparam logic [8:0] HB_START9  = 9'(HB_START);
  localparam logic [8:0] HB_END9    = 9'(HB_END);
  localparam logic [8:0] HS_START9  = 9'(HS_START);
  localparam logic [8:0] HS_END9    = 9'(HS_END);
  localparam logic [8:0] VS_START9  = 9'(VS_START);
  localparam logic [8:0] VS_END9    = 9'(VS_END);
  localparam logic [8:0] VB_START9  = 9'(VB_START);
  localparam logic [8:0] VB_END9    = 9'(VB_END);
  localparam logic [8:0] VB_HPOS9   = 9'(HB_END - 4);
  localparam logic [8:0] INT_HPOS9  = 9'(INT_HPOS);

  logic [8:0]        lint     [NUM_LINT];
  logic [8:0]        lint_eff [NUM_LINT];
  logic [NUM_LINT:0] set_ev;
  logic              h_wrap;
  logic              v_wrap;
  logic              fetch_hit;
  logic [8:0]        col_off;

  assign h_wrap    = (hc == H_LAST);
  assign v_wrap    = (vc == V_LAST);
  assign fetch_hit = (vc < V_ACT9) && (hc >= H_ACT9) && (hc[2:0] == 3'd0);
  assign col_off   = hc - H_ACT9;

  // A write landing on the compare cycle is forwarded so the new line number wins.
  always_comb begin
    set_ev = '0;
    for (int i = 0; i < NUM_LINT; i++) begin
      lint_eff[i] = (lint_we && (lint_sel == 3'(i))) ? lint_din : lint[i];
      set_ev[i]   = ce_pix && (hc == INT_HPOS9) && (vc == lint_eff[i]) && (lint_eff[i] < V_ACT9);
    end
    set_ev[NUM_LINT] = ce_pix && (hc == INT_HPOS9) && (vc == VS_START9);
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      hc        <= '0;
      vc        <= '0;
      flashcnt  <= '0;
      int_pend  <= '0;
      irq       <= 1'b0;
      fetch     <= 1'b0;
      fetch_col <= '0;
      fetch_row <= '0;
      hsync     <= 1'b0;
      hblank    <= 1'b0;
      vsync     <= 1'b0;
      vblank    <= 1'b1;
      for (int i = 0; i < NUM_LINT; i++) lint[i] <= 9'h1FF;
    end else begin
      fetch    <= 1'b0;
      irq      <= |int_pend;
      int_pend <= set_ev | (int_pend & ~int_ack);
      for (int i = 0; i < NUM_LINT; i++) begin
        if (lint_we && (lint_sel == 3'(i))) lint[i] <= lint_din;
      end
      if (ce_pix) begin
        hc <= h_wrap ? 9'd0 : hc + 9'd1;
        if (h_wrap) begin
          vc <= v_wrap ? 9'd0 : vc + 9'd1;
          if (v_wrap) flashcnt <= flashcnt + 1'b1;
        end
        hblank <= (hc >= HB_START9) && (hc < HB_END9);
        hsync  <= (hc >= HS_START9) && (hc < HS_END9);
        if (hc == HS_START9) begin
          if (vc == VS_START9)    vsync <= 1'b1;
          else if (vc == VS_END9) vsync <= 1'b0;
        end
        if (hc == VB_HPOS9) begin
          if (vc == VB_START9)    vblank <= 1'b1;
          else if (vc == VB_END9) vblank <= 1'b0;
        end
        if (fetch_hit) begin
          fetch     <= 1'b1;
          fetch_col <= col_off[7:3];
          fetch_row <= vc[7:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_video_raster_gen.sv
// Randomized bench for video_raster_gen on a shrunken raster, compared every clock against
// a model that derives position from a running pixel count.
module tb_video_raster_gen;

  localparam int H_TOTAL  = 64;
  localparam int V_TOTAL  = 40;
  localparam int H_ACT    = 24;
  localparam int V_ACT    = 24;
  localparam int HB_START = 4;
  localparam int HB_END   = 16;
  localparam int HS_START = 6;
  localparam int HS_END   = 10;
  localparam int VS_START = 30;
  localparam int VS_END   = 32;
  localparam int VB_START = 28;
  localparam int VB_END   = 34;
  localparam int INT_HPOS = 3;
  localparam int NUM_LINT = 2;
  localparam int FLASH_W  = 5;
  localparam int FRAME    = H_TOTAL * V_TOTAL;

  logic                clk_sys = 1'b0;
  logic                reset_n = 1'b0;
  logic                ce_pix = 1'b0;
  logic                lint_we = 1'b0;
  logic [2:0]          lint_sel = '0;
  logic [8:0]          lint_din = '0;
  logic [NUM_LINT:0]   int_ack = '0;
  logic [8:0]          hc, vc;
  logic                hsync, hblank, vsync, vblank, fetch, irq;
  logic [4:0]          fetch_col;
  logic [7:0]          fetch_row;
  logic [FLASH_W-1:0]  flashcnt;
  logic [NUM_LINT:0]   int_pend;

  video_raster_gen #(
    .H_TOTAL(H_TOTAL), .V_TOTAL(V_TOTAL), .H_ACT(H_ACT), .V_ACT(V_ACT),
    .HB_START(HB_START), .HB_END(HB_END), .HS_START(HS_START), .HS_END(HS_END),
    .VS_START(VS_START), .VS_END(VS_END), .VB_START(VB_START), .VB_END(VB_END),
    .INT_HPOS(INT_HPOS), .NUM_LINT(NUM_LINT), .FLASH_W(FLASH_W)
  ) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ce_pix(ce_pix), .lint_we(lint_we),
    .lint_sel(lint_sel), .lint_din(lint_din), .int_ack(int_ack), .hc(hc), .vc(vc),
    .hsync(hsync), .hblank(hblank), .vsync(vsync), .vblank(vblank), .fetch(fetch),
    .fetch_col(fetch_col), .fetch_row(fetch_row), .flashcnt(flashcnt),
    .int_pend(int_pend), .irq(irq)
  );

  // clock / reset
  always #5 clk_sys = ~clk_sys;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else begin
      n_fail++;
      if (n_fail <= 30)
        $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
    end
  endtask

  // reference model: position comes from the number of pixels since reset
  int   m_pix = 0;
  bit   m_hs, m_hb, m_vs, m_vb, m_fetch, m_irq;
  int   m_col, m_row;
  bit   m_pend [NUM_LINT+1];
  int   m_lint [NUM_LINT];
  int   fetch_on_line;
  bit   seen_lint0;
  logic [31:0] exp_q[$];

  function automatic logic [31:0] pend_word();
    logic [31:0] w = '0;
    for (int i = 0; i <= NUM_LINT; i++) w[i] = m_pend[i];
    return w;
  endfunction

  task automatic model_step(input bit rn, input bit ce, input bit we, input int sel,
                            input int din, input logic [NUM_LINT:0] ack);
    int oh, ov, eff;
    bit any;
    bit setv [NUM_LINT+1];
    if (!rn) begin
      m_pix = 0; m_hs = 0; m_hb = 0; m_vs = 0; m_vb = 1; m_fetch = 0; m_irq = 0;
      m_col = 0; m_row = 0;
      for (int i = 0; i <= NUM_LINT; i++) m_pend[i] = 0;
      for (int i = 0; i < NUM_LINT; i++) m_lint[i] = 511;
      return;
    end
    any = 0;
    for (int i = 0; i <= NUM_LINT; i++) begin any |= m_pend[i]; setv[i] = 0; end
    m_fetch = 0;
    if (ce) begin
      oh = m_pix % H_TOTAL;
      ov = (m_pix / H_TOTAL) % V_TOTAL;
      m_hb = (oh >= HB_START && oh < HB_END);
      m_hs = (oh >= HS_START && oh < HS_END);
      if (oh == HS_START && ov == VS_START) m_vs = 1;
      if (oh == HS_START && ov == VS_END)   m_vs = 0;
      if (oh == HB_END - 4 && ov == VB_START) m_vb = 1;
      if (oh == HB_END - 4 && ov == VB_END)   m_vb = 0;
      if (ov < V_ACT && oh >= H_ACT && oh % 8 == 0) begin
        m_fetch = 1;
        m_col = ((oh - H_ACT) / 8) % 32;
        m_row = ov % 256;
      end
      for (int i = 0; i < NUM_LINT; i++) begin
        eff = (we && sel == i) ? din : m_lint[i];
        setv[i] = (oh == INT_HPOS && ov == eff && eff < V_ACT);
      end
      setv[NUM_LINT] = (oh == INT_HPOS && ov == VS_START);
      m_pix++;
    end
    for (int i = 0; i <= NUM_LINT; i++) m_pend[i] = setv[i] || (m_pend[i] && !ack[i]);
    if (we && sel < NUM_LINT) m_lint[sel] = din;
    m_irq = any;
  endtask

  task automatic compare_all();
    exp_q.push_back(32'(m_pix % H_TOTAL));
    exp_q.push_back(32'((m_pix / H_TOTAL) % V_TOTAL));
    exp_q.push_back(32'((m_pix / FRAME) % 32));
    exp_q.push_back(pend_word());
    check("hc", 32'(hc), exp_q.pop_front());
    check("vc", 32'(vc), exp_q.pop_front());
    check("flashcnt", 32'(flashcnt), exp_q.pop_front());
    check("int_pend", 32'(int_pend), exp_q.pop_front());
    check("hsync", 32'(hsync), 32'(m_hs));
    check("hblank", 32'(hblank), 32'(m_hb));
    check("vsync", 32'(vsync), 32'(m_vs));
    check("vblank", 32'(vblank), 32'(m_vb));
    check("fetch", 32'(fetch), 32'(m_fetch));
    check("fetch_col", 32'(fetch_col), 32'(m_col));
    check("fetch_row", 32'(fetch_row), 32'(m_row));
    check("irq", 32'(irq), 32'(m_irq));
    if (int_pend[0]) seen_lint0 = 1;
    if (fetch && vc == 9'd0) fetch_on_line++;
  endtask

  // driver: inputs change on the falling edge, outputs sampled 1 ns after the rising edge
  task automatic drive_cycle(input bit rn, input bit ce, input bit we, input int sel,
                             input int din, input logic [NUM_LINT:0] ack);
    @(negedge clk_sys);
    reset_n = rn; ce_pix = ce; lint_we = we;
    lint_sel = 3'(sel); lint_din = 9'(din); int_ack = ack;
    @(posedge clk_sys);
    #1;
    model_step(rn, ce, we, sel, din, ack);
    compare_all();
  endtask

  task automatic run_random(input int cycles, input int ce_pct, input bit do_writes);
    bit ce, we;
    int sel, din;
    logic [NUM_LINT:0] ack;
    for (int c = 0; c < cycles; c++) begin
      ce  = ($urandom_range(0, 99) < ce_pct);
      we  = do_writes && ($urandom_range(0, 299) == 0);
      sel = $urandom_range(0, 3);
      din = $urandom_range(0, V_ACT + 8);
      ack = ($urandom_range(0, 39) == 0) ? (NUM_LINT+1)'($urandom) : '0;
      drive_cycle(1'b1, ce, we, sel, din, ack);
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) drive_cycle(1'b0, i[0], 1'b0, 0, 0, '0);

    // line 10 enabled on channel 0, channel 1 parked on a non-active line
    drive_cycle(1'b1, 1'b0, 1'b1, 0, 10, '0);
    drive_cycle(1'b1, 1'b0, 1'b1, 1, V_ACT + 6, '0);
    fetch_on_line = 0;
    for (int c = 0; c < FRAME * 4 + 40; c++)
      drive_cycle(1'b1, (c % 4) == 3, 1'b0, 0, 0, '0);
    check("line0_fetches", 32'(fetch_on_line), 32'((H_TOTAL - H_ACT) / 8));
    check("lint0_seen", 32'(seen_lint0), 32'd1);

    run_random(FRAME * 2, 60, 1'b1);

    // mid-frame reset, then a frame with no writes so only the frame interrupt may fire
    for (int c = 0; c < 5000 && !(vc == 9'd12 && hc == 9'd40); c++)
      drive_cycle(1'b1, 1'b1, 1'b0, 0, 0, '0);
    drive_cycle(1'b0, 1'b1, 1'b0, 0, 0, '0);
    run_random(FRAME + 100, 100, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/video_raster_gen.md
VIDEO_RASTER_GEN -- requirements
Module: video_raster_gen

Interface
REQ-001 The module SHALL have the following parameters (name, default, meaning):
- H_TOTAL, 384: pixel clocks per line.
- V_TOTAL, 312: lines per frame.
- H_ACT, 128: first active hc; the active area runs to H_TOTAL-1.
- V_ACT, 192: active lines, vc 0..V_ACT-1.
- HB_START/HB_END, 32/112: hblank window [start, end).
- HS_START/HS_END, 48/80: hsync window [start, end).
- VS_START/VS_END, 240/244: vsync line window.
- VB_START/VB_END, 236/260: vblank line window.
- INT_HPOS, 3: hc at which interrupts are raised.
- NUM_LINT, 2: number of line-interrupt channels (1..8).
- FLASH_W, 5: flash counter width.

REQ-002 The module SHALL have the following ports (name, direction, width, meaning):
- clk_sys, in, 1: master clock.
- reset_n, in, 1: reset; one clock; reset is synchronous and active-low.
- ce_pix, in, 1: pixel clock enable.
- lint_we, in, 1: line-interrupt register write strobe, one clk_sys.
- lint_sel, in, 3: channel index.
- lint_din, in, 9: line number.
- int_ack, in, NUM_LINT+1: clear mask; bit NUM_LINT is frame.
- hc, out, 9: horizontal counter.
- vc, out, 9: vertical counter.
- hsync, hblank, vsync, vblank, out, 1 each: raster timing.
- fetch, out, 1: one-clock fetch strobe.
- fetch_col, out, 5: column of the current fetch.
- fetch_row, out, 8: row of the current fetch.
- flashcnt, out, FLASH_W: frame counter.
- int_pend, out, NUM_LINT+1: pending interrupt flags.
- irq, out, 1: OR of int_pend.

Function
REQ-003 All state SHALL change only on clk_sys rising edges; counters and timing outputs SHALL update only when ce_pix=1.
REQ-004 On ce_pix, hc SHALL increment, and SHALL wrap from H_TOTAL-1 to 0.
REQ-005 vc SHALL increment when hc wraps, and SHALL wrap from V_TOTAL-1 to 0.
REQ-006 flashcnt SHALL increment modulo 2^FLASH_W when vc and hc wrap together.
REQ-007 hblank and hsync SHALL be registered from the pre-increment hc, i.e. one ce_pix after the matching count.
- hblank=1 for hc in [HB_START, HB_END).
- hsync=1 for hc in [HS_START, HS_END).
REQ-008 vsync SHALL change only on the ce_pix with hc==HS_START.
- Set when vc==VS_START.
- Cleared when vc==VS_END.
REQ-009 vblank SHALL change only on the ce_pix with hc==HB_END-4.
- Set when vc==VB_START.
- Cleared when vc==VB_END.
REQ-010 fetch SHALL pulse for exactly one clk_sys on each ce_pix where all of the following hold: vc<V_ACT, hc>=H_ACT, hc[2:0]==0.
- fetch_col SHALL be (hc-H_ACT)>>3.
- fetch_row SHALL be vc[7:0].
- Both SHALL be held until the next fetch.
REQ-011 lint_we with lint_sel<NUM_LINT SHALL load lint_din into lint[lint_sel] on the next clk_sys; writes with lint_sel>=NUM_LINT SHALL be ignored.
REQ-012 Channel i SHALL set int_pend[i] on the ce_pix where hc==INT_HPOS and vc==lint[i] and lint[i]<V_ACT; any other value of lint[i] disables channel i.
REQ-013 int_pend[NUM_LINT] SHALL set on the ce_pix where hc==INT_HPOS and vc==VS_START.
REQ-014 Each int_pend bit SHALL stay set until cleared by int_ack; set and ack on the same clk_sys SHALL leave the bit set.
REQ-015 irq SHALL be registered and SHALL equal |int_pend, with one clk_sys latency.
REQ-016 A lint write that takes effect on the same ce_pix as the compare SHALL use the new value.

Reset
REQ-017 While reset_n=0 on a clk_sys edge, the following SHALL be forced regardless of ce_pix:
- hc, vc, flashcnt, int_pend, irq, fetch, fetch_col, fetch_row SHALL be 0.
- hsync, vsync, hblank SHALL be 0.
- vblank SHALL be 1.
- All lint registers SHALL be 9'h1FF (disabled).
REQ-018 Reset asserted mid-frame SHALL abort the frame; the first ce_pix after release SHALL give hc=1, vc=0.

Verification
REQ-019 Defaults, ce_pix every 4th clk, run two frames:
- hsync high for 32 ce_pix per line.
- Exactly 384 ce_pix per line.
- vc returns to 0 after 312 lines.
- flashcnt increments by 1 per frame.
REQ-020 Active line 0:
- 32 fetch pulses per line, fetch_col 0..31 in order.
- No fetch on line 192.
- No fetch when hc<128.
REQ-021 Write lint[0]=10 and lint[1]=200 (disabled):
- int_pend[0] rises at vc=10, hc=3.
- int_pend[1] never rises.
- irq rises one clk_sys after int_pend[0].
REQ-022 Pending line interrupt, int_ack=3'b001 asserted on the same clk as a new set event -> bit stays 1; int_ack=3'b001 one clk later -> bit 0.
REQ-023 Frame interrupt: int_pend[2] rises at vc=240, hc=3; it stays set across 312 lines without ack.
REQ-024 reset_n=0 for 1 clk at vc=100, hc=200:
- All outputs take their reset values.
- lint registers read back as disabled, so no line interrupt fires on the next frame.
